// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin packet multiplexer: FSM state
// encoding, a lowest-set-bit picker and the beat-counter width helper.
package rr_mux_pkg;

    // Two-state lock FSM: IDLE requests arbitration, LOCK streams one channel.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Widest request vector the one-hot helper handles; callers zero-extend
    // into it and truncate the result back to their own width.
    localparam int ONEHOT_W = 32;

    // Isolate the lowest set bit of a vector (two's-complement trick).
    // A zero input returns zero.
    function automatic logic [ONEHOT_W-1:0] f_lowest_onehot(
        input logic [ONEHOT_W-1:0] v
    );
        return v & (~v + ONEHOT_W'(1));
    endfunction

    // Counter wide enough to hold the value max_burst itself, so the counter
    // can sit at the limit after a truncating release.
    function automatic int f_cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rr_out_reg.sv
// One-entry valid/ready register slice. Full throughput: a new word may be
// loaded in the same cycle the held word is taken downstream.
//
// Handshake: a word moves across an interface on a rising clock edge where
// valid and ready are both high. Valid, once raised, holds its word stable
// until that transfer; ready may depend combinationally on the downstream
// ready (o_ready = ~o_valid | i_ready).
module rr_out_reg #(
    parameter int WIDTH = 33
) (
    input  logic             sys_clk_i,
    input  logic             rst_i,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Load on upstream transfer; empty when drained without a refill.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_packet_mux.sv
// Packet-level multiplexer sitting behind a round-robin arbiter. In IDLE it
// mirrors channel valids onto the arbiter request; a grant that matches a
// valid channel locks that channel, and its beats are forwarded through a
// one-entry output register until end-of-packet or MAX_BURST beats.
// REQUIRE_NUM must not exceed rr_mux_pkg::ONEHOT_W.
module rr_packet_mux
    import rr_mux_pkg::*;
#(
    parameter int REQUIRE_NUM = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BURST   = 16
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_i,
    input  logic [REQUIRE_NUM-1:0]          s_valid_i,
    input  logic [REQUIRE_NUM*DATA_WIDTH-1:0] s_data_i,
    input  logic [REQUIRE_NUM-1:0]          s_last_i,
    output logic [REQUIRE_NUM-1:0]          s_ready_o,
    output logic [REQUIRE_NUM-1:0]          request_o,
    input  logic [REQUIRE_NUM-1:0]          respond_i,
    output logic                            m_valid_o,
    output logic [DATA_WIDTH-1:0]           m_data_o,
    output logic                            m_last_o,
    input  logic                            m_ready_i,
    output logic [REQUIRE_NUM-1:0]          lock_ch_o,
    output logic                            trunc_o
);

    localparam int                CNT_W   = f_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);

    // Registered state
    state_t                   r_state;
    logic [REQUIRE_NUM-1:0]   r_lock;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_trunc;

    // Next-state values
    state_t                   w_state_nxt;
    logic [REQUIRE_NUM-1:0]   w_lock_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_trunc_nxt;

    // Datapath / decision wires
    logic [REQUIRE_NUM-1:0]   w_hit;
    logic [REQUIRE_NUM-1:0]   w_pick;
    logic                     w_sel_valid;
    logic                     w_sel_last;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic                     w_out_free;
    logic                     w_accept;
    logic [CNT_W-1:0]         w_cnt_inc;
    logic                     w_at_limit;
    logic                     w_out_last;
    logic [DATA_WIDTH-1:0]    w_out_data;

    // A grant only counts for a channel that is actually presenting a beat;
    // if the arbiter hands back several bits the lowest index wins.
    assign w_hit  = respond_i & s_valid_i;
    assign w_pick = REQUIRE_NUM'(f_lowest_onehot(ONEHOT_W'(w_hit)));

    // Beat counting: the accept that brings the count to MAX_BURST closes the lock.
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_at_limit = (w_cnt_inc == CNT_MAX);

    // Only the locked channel may push into the output register.
    assign w_accept = (r_state == ST_LOCK) && w_sel_valid && w_out_free;

    // One-hot AND-OR select of the locked channel's valid, data and last.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < REQUIRE_NUM; k++) begin
            if (r_lock[k]) begin
                w_sel_valid = w_sel_valid | s_valid_i[k];
                w_sel_last  = w_sel_last  | s_last_i[k];
                w_sel_data  = w_sel_data  | s_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lock FSM: next state, lock vector, counter, truncation flag and the
    // combinational request/ready outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock;
        w_cnt_nxt   = r_cnt;
        w_trunc_nxt = 1'b0;
        request_o   = '0;
        s_ready_o   = '0;
        unique case (r_state)
            ST_IDLE: begin
                // Held low during reset so every output reads zero.
                request_o = s_valid_i & ~{REQUIRE_NUM{rst_i}};
                if (|w_hit) begin
                    w_state_nxt = ST_LOCK;
                    w_lock_nxt  = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK: begin
                s_ready_o = r_lock & {REQUIRE_NUM{w_out_free}};
                if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_sel_last || w_at_limit) begin
                        // Last wins when it coincides with the limit.
                        w_state_nxt = ST_IDLE;
                        w_lock_nxt  = '0;
                        w_trunc_nxt = ~w_sel_last;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lock_nxt  = '0;
            end
        endcase
    end

    // State, lock, counter and truncation pulse registers.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_lock  <= '0;
            r_cnt   <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lock  <= w_lock_nxt;
            r_cnt   <= w_cnt_nxt;
            r_trunc <= w_trunc_nxt;
        end
    end

    // Output stage carries {last, data}; it keeps draining after the lock
    // has already dropped back to IDLE.
    rr_out_reg #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_out_reg (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .i_valid   (w_accept),
        .o_ready   (w_out_free),
        .i_data    ({w_sel_last, w_sel_data}),
        .o_valid   (m_valid_o),
        .i_ready   (m_ready_i),
        .o_data    ({w_out_last, w_out_data})
    );

    assign m_last_o  = w_out_last;
    assign m_data_o  = w_out_data;
    assign lock_ch_o = r_lock;
    assign trunc_o   = r_trunc;

endmodule

// File: tb/tb_rr_packet_mux.sv
// Bench for rr_packet_mux. Sources replay per-channel beat queues, a
// round-robin arbiter (or a forced grant) answers the request vector, and a
// monitor checks every output beat against per-channel expected queues built
// from the packet rules: each channel's stream is cut into segments that end
// at last or after MAX_BURST beats, and segments must leave whole.
// Beat data carries its channel number in bits [31:28].
module tb_rr_packet_mux;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst     = 1'b1;
    logic [N-1:0]   s_valid = '0;
    logic [N*W-1:0] s_data  = '0;
    logic [N-1:0]   s_last  = '0;
    logic [N-1:0]   s_ready;
    logic [N-1:0]   request;
    logic [N-1:0]   respond;
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_ready = 1'b0;
    logic [N-1:0]   lock_ch;
    logic           trunc;

    rr_packet_mux #(
        .REQUIRE_NUM (N),
        .DATA_WIDTH  (W),
        .MAX_BURST   (MB)
    ) dut (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .s_valid_i (s_valid),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .request_o (request),
        .respond_i (respond),
        .m_valid_o (m_valid),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_ready_i (m_ready),
        .lock_ch_o (lock_ch),
        .trunc_o   (trunc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus knobs
    int           gap_pct    = 0;
    int           ready_pct  = 100;
    bit           arb_force  = 1'b1;
    logic [N-1:0] force_resp = '0;

    // Source beats {last, data} and expected beats {seg_end, last, data}
    logic [W:0]   src_q [N][$];
    logic [W+1:0] exp_q [N][$];
    int           seg_cnt [N];
    int           exp_trunc  = 0;
    int           trunc_seen = 0;
    int           beats_seen = 0;
    int           cur_ch     = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pre-edge sample point of the next cycle.
    task automatic tick();
        @(negedge clk);
        #4;
    endtask

    // Queue a beat and derive its expected segmentation.
    task automatic push_beat(input int ch, input logic [W-1:0] d, input logic lst);
        logic seg_end;
        src_q[ch].push_back({lst, d});
        seg_cnt[ch]++;
        seg_end = lst || (seg_cnt[ch] == MB);
        if (seg_end) begin
            if (!lst) exp_trunc++;
            seg_cnt[ch] = 0;
        end
        exp_q[ch].push_back({seg_end, lst, d});
    endtask

    task automatic push_rand(input int ch, input logic lst);
        logic [W-1:0] d;
        d = {4'(ch), 28'($urandom)};
        push_beat(ch, d, lst);
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int k = 0; k < N; k++)
            if (src_q[k].size() != 0 || exp_q[k].size() != 0) e = 1'b0;
        return e;
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int ptr);
        logic [N-1:0] g;
        int idx;
        g = '0;
        for (int j = 0; j < N; j++) begin
            idx = (ptr + j) % N;
            if (g == '0 && req[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Arbiter stand-in: forced grant or round-robin over request_o.
    int rr_ptr = 0;
    always_comb begin
        respond = arb_force ? force_resp : rr_pick(request, rr_ptr);
    end

    // Source driver: present queue heads at negedge, note accepts before the edge.
    logic [N-1:0] acc = '0;
    int grant_idx = -1;
    always begin
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < N; k++)
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (grant_idx >= 0) rr_ptr = (grant_idx + 1) % N;
        end
        acc = '0;
        grant_idx = -1;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && $urandom_range(99) >= gap_pct) begin
                s_valid[k] = 1'b1;
                {s_last[k], s_data[k*W +: W]} = src_q[k][0];
            end else begin
                s_valid[k] = 1'b0;
                s_last[k] = 1'b0;
                s_data[k*W +: W] = '0;
            end
        end
        m_ready = ($urandom_range(99) < ready_pct);
        #4;
        if (!rst) begin
            acc = s_valid & s_ready;
            if (!arb_force)
                for (int k = 0; k < N; k++)
                    if (grant_idx < 0 && respond[k] && s_valid[k]) grant_idx = k;
        end
    end

    // Monitor: invariants every cycle, scoreboard on each output transfer.
    bit         hold_prev = 1'b0;
    logic [W:0] hold_val  = '0;
    always begin : mon
        int ch;
        logic [W+1:0] e;
        @(negedge clk);
        #4;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (lock_ch != '0) check("request_in_lock", request, '0);
            check("ready_outside_lock", s_ready & ~lock_ch, '0);
            check("lock_onehot0", $onehot0(lock_ch), 1);
            if (m_valid && !m_ready) check("ready_when_blocked", s_ready, '0);
            if (hold_prev) begin
                check("held_valid", m_valid, 1);
                check("held_beat", {m_last, m_data}, hold_val);
            end
            if (trunc) trunc_seen++;
            if (m_valid && m_ready) begin
                beats_seen++;
                ch = int'(m_data[31:28]);
                if (ch >= N || exp_q[ch].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected none", m_data);
                end else begin
                    e = exp_q[ch].pop_front();
                    check("beat_data", m_data, e[W-1:0]);
                    check("beat_last", m_last, e[W]);
                    if (cur_ch >= 0) check("no_interleave", ch, cur_ch);
                    cur_ch = e[W+1] ? -1 : ch;
                end
            end
            hold_prev = m_valid && !m_ready;
            hold_val  = {m_last, m_data};
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_data"},  m_data,  0);
        check({name, "_m_last"},  m_last,  0);
        check({name, "_lock"},    lock_ch, 0);
        check({name, "_trunc"},   trunc,   0);
        check({name, "_s_ready"}, s_ready, 0);
        check({name, "_request"}, request, 0);
    endtask

    task automatic phase_end(input string name, input int max_cyc);
        bit done;
        done = all_empty();
        for (int c = 0; c < max_cyc && !done; c++) begin
            tick();
            done = all_empty();
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got pending beats expected none after %0d cycles", name, max_cyc);
        end
        repeat (3) tick();
        check({name, "_trunc_count"}, trunc_seen, exp_trunc);
        check({name, "_idle_lock"}, lock_ch, 0);
        trunc_seen = 0;
        exp_trunc  = 0;
    endtask

    task automatic wait_beats(input int target, input int max_cyc, input string name);
        bit ok;
        ok = (beats_seen >= target);
        for (int c = 0; c < max_cyc && !ok; c++) begin
            tick();
            ok = (beats_seen >= target);
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_wait: got %0d beats expected %0d", name, beats_seen, target);
        end
    endtask

    initial begin
        int lock_cycles, mv_cnt, first_mv, last_mv, base;
        bit reacq, got_lock;
        logic [N-1:0] first_lock;

        for (int k = 0; k < N; k++) seg_cnt[k] = 0;

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // Single packet on ch2 with a steady grant
        arb_force = 1'b1;
        force_resp = 4'b0100;
        for (int i = 0; i < 3; i++) push_beat(2, 32'h2000_00A0 + 32'(i), i == 2);
        lock_cycles = 0; mv_cnt = 0; first_mv = -1; last_mv = -1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (lock_ch == 4'b0100) lock_cycles++;
            if (m_valid) begin
                mv_cnt++;
                if (first_mv < 0) first_mv = c;
                last_mv = c;
            end
        end
        check("single_lock_cycles", lock_cycles, 3);
        check("single_beats", mv_cnt, 3);
        check("single_back_to_back", last_mv - first_mv, 2);
        phase_end("single", 50);

        // Burst limit: six beats without last, then a closing beat
        force_resp = 4'b0001;
        for (int i = 0; i < 6; i++) push_rand(0, 1'b0);
        push_rand(0, 1'b1);
        reacq = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (trunc && lock_ch == '0 && request[0]) reacq = 1'b1;
        end
        check("burst_rerequest", reacq, 1);
        phase_end("burst", 50);

        // Backpressure mid-packet; last coincides with the burst limit
        force_resp = 4'b0010;
        base = beats_seen;
        for (int i = 0; i < 4; i++) push_rand(1, i == 3);
        wait_beats(base + 2, 30, "bp");
        ready_pct = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid_held", m_valid, 1);
            check("bp_s_ready", s_ready, '0);
        end
        ready_pct = 100;
        phase_end("backpressure", 50);

        // Stale grant: ch3 granted without valid
        force_resp = 4'b1000;
        push_rand(0, 1'b0);
        push_rand(0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("stale_idle", lock_ch, '0);
        end
        // Multi-hot grant resolves to lowest index
        force_resp = 4'b0110;
        push_rand(1, 1'b0); push_rand(1, 1'b1);
        push_rand(2, 1'b0); push_rand(2, 1'b1);
        got_lock = 1'b0;
        first_lock = '0;
        for (int c = 0; c < 10 && !got_lock; c++) begin
            tick();
            if (lock_ch != '0) begin
                got_lock = 1'b1;
                first_lock = lock_ch;
            end
        end
        check("multihot_lock", first_lock, 4'b0010);
        arb_force = 1'b0;
        phase_end("grant", 100);

        // Reset during beat 2 of 4
        base = beats_seen;
        for (int i = 0; i < 4; i++) push_rand(3, i == 3);
        wait_beats(base + 1, 30, "rst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
            seg_cnt[k] = 0;
        end
        cur_ch = -1;
        exp_trunc = 0;
        trunc_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        check_all_zero("after_reset");
        for (int i = 0; i < 3; i++) push_rand(3, i == 2);
        phase_end("clean_lock", 50);

        // Randomized traffic with gaps and backpressure
        gap_pct = 30;
        ready_pct = 70;
        for (int p = 0; p < 40; p++) begin
            int ch, len;
            bit has_last;
            ch = $urandom_range(N - 1);
            len = $urandom_range(6, 1);
            has_last = ($urandom_range(3) != 0);
            for (int i = 0; i < len; i++) push_rand(ch, has_last && (i == len - 1));
        end
        for (int k = 0; k < N; k++) push_rand(k, 1'b1);
        phase_end("random", 4000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_packet_mux.md
# rr_packet_mux

Packet-level data multiplexer downstream of the `round_robin` arbiter. It drives the arbiter's request vector from per-channel valid, and latches the one-hot grant returned by the arbiter. It then forwards the granted channel's stream beat-by-beat to a single output until end-of-packet or a burst limit. The grant stays locked for the whole packet.

## Interface
- `REQUIRE_NUM`, 4: number of input channels; must match the arbiter's `REQUIRE_NUM`.
- `DATA_WIDTH`, 32: beat data width.
- `MAX_BURST`, 16: maximum beats per lock; must be ≥1.

- `sys_clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `s_valid_i`  in  REQUIRE_NUM  per-channel beat valid.
- `s_data_i`  in  REQUIRE_NUM*DATA_WIDTH  flattened data; channel k occupies `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_last_i`  in  REQUIRE_NUM  per-channel end-of-packet.
- `s_ready_o`  out  REQUIRE_NUM  per-channel beat accept.
- `request_o`  out  REQUIRE_NUM  connects to the arbiter's `request_i`.
- `respond_i`  in  REQUIRE_NUM  connects to the arbiter's `respond_o`; one-hot or zero.
- `m_valid_o`  out  1  output beat valid.
- `m_data_o`  out  DATA_WIDTH  output beat data.
- `m_last_o`  out  1  output end-of-packet (copy of the source `s_last_i`).
- `m_ready_i`  in  1  output accept.
- `lock_ch_o`  out  REQUIRE_NUM  one-hot locked channel; 0 when idle.
- `trunc_o`  out  1  one-cycle pulse when a lock is released by `MAX_BURST` rather than by last.

## Operation
- FSM states: IDLE, LOCK.
- **IDLE**
  - `request_o = s_valid_i`.
  - `s_ready_o = 0`.
  - Each cycle compute `hit = respond_i & s_valid_i`.
  - If `hit != 0`: latch `lock_ch_o` = lowest set bit of `hit`, clear the beat counter, go to LOCK.
  - Grants for channels without valid are ignored.
  - A multi-hot `respond_i` resolves to the lowest index.
- **LOCK**
  - `request_o = 0`.
  - `respond_i` is ignored.
  - `s_ready_o = lock_ch_o & {REQUIRE_NUM{out_free}}`, where `out_free = ~m_valid_o | m_ready_i`.
  - A beat is accepted when `s_valid_i[c] & s_ready_o[c]` for the locked channel c.
  - On accept, the output register loads data and last from channel c, and the beat counter increments.
- **Release** occurs on the accept cycle when `s_last_i[c]=1` or when the counter reaches `MAX_BURST`. Next state is IDLE and `lock_ch_o` clears.
  - If the release is by limit with last=0, pulse `trunc_o`.
  - If last and limit coincide, the release counts as last and there is no `trunc_o`.
- **Output register**: one entry, full throughput. `m_valid_o` is set on accept and cleared on `m_ready_i` without a simultaneous accept. Held data stays stable while `m_valid_o & ~m_ready_i`.
- Returning to IDLE does not wait for the output register to drain; a pending beat drains in IDLE.
- The beat counter is `$clog2(MAX_BURST+1)` bits and saturates at release.

## Timing
- Reset value of every output: 0. State resets to IDLE and the output register to empty.
- Reset mid-packet discards the in-flight beat and the lock with no partial `m_last_o`.
- `request_o` and `s_ready_o` are combinational from state/registers and inputs. All other outputs are registered.
- Grant to lock: `respond_i` hit sampled at edge N → LOCK from N+1, first accept possible in cycle N+1.
- Input accept to `m_valid_o`: 1 cycle.
- Release at edge N → IDLE in cycle N+1. `request_o` reasserts in N+1, so the earliest next lock is at edge N+1.
- Back-to-back beats on one channel with `m_ready_i=1`: 1 beat/cycle sustained.
- `m_ready_i=0` with a full register: `s_ready_o=0`, and the lock is held indefinitely.
- A source dropping `s_valid_i` mid-packet keeps the lock; there is no timeout.

## Structure
- The shared package `rr_mux_pkg` holds:
  - the state encoding (IDLE=1'b0, LOCK=1'b1);
  - the lowest-set-bit one-hot function;
  - the counter-width function based on `$clog2`.
- One sub-module: `rr_out_reg`, a one-entry valid/ready register slice of width `DATA_WIDTH+1` carrying data and last.
- Top level: FSM, lock register, beat counter, channel select mux.

## Test plan
- **Single packet.** Reset, then ch2 sends 3 beats `0xA0..0xA2` with last on the 3rd, `respond_i=4'b0100` driven from IDLE, `m_ready_i=1`.
  - Expect `lock_ch_o=4'b0100` for 3 cycles.
  - Expect `m_data_o` A0, A1, A2 on consecutive cycles with `m_last_o` on A2.
  - Expect `request_o=0` during the lock.
- **All-channel rotation.** All 4 channels valid with 2-beat packets; connect the real `round_robin`.
  - Expect packets to leave whole and non-interleaved, and every channel to be served within 4 packets.
- **Burst limit.** `MAX_BURST=4`, ch0 sends 6 beats with no last.
  - Expect release after beat 4, `trunc_o` pulse, and `m_last_o=0`; ch0 is re-requested in IDLE.
- **Backpressure.** `m_ready_i=0` for 5 cycles mid-packet.
  - Expect `m_data_o` stable, `s_ready_o=0`, and no beat lost or duplicated after release.
- **Stale/bad grant.** `respond_i=4'b1000` while `s_valid_i[3]=0` → stays IDLE. `respond_i=4'b0110` with both valid → locks ch1.
- **Reset mid-packet.** Assert `rst_i` asynchronously on beat 2 of 4.
  - Expect all outputs 0 immediately; after release, the next grant starts a clean lock.
